// File: rtl/rpn_evaluator.sv
// rpn_evaluator: reverse-Polish token evaluator driving an external push/pop stack
module rpn_evaluator #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tok_valid,
    input  logic                       tok_is_op,
    input  logic [WIDTH-1:0]           tok_data,
    output logic                       tok_ready,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_din,
    input  logic [WIDTH-1:0]           stk_dout,
    input  logic [$clog2(DEPTH):0]     stk_size,
    input  logic                       stk_empty,
    input  logic                       stk_full,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [1:0]                 err_code
);
    localparam int SW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, PUSH, POP_B, EXEC, DONE, ERR, FLUSH} state_t;

    state_t           state, state_n;
    logic [1:0]       op, op_n, err_n;
    logic [WIDTH-1:0] b_reg, b_n, din_r, din_n, res_n, alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= '0;
            b_reg    <= '0;
            din_r    <= '0;
            res_data <= '0;
            err_code <= '0;
        end else begin
            state    <= state_n;
            op       <= op_n;
            b_reg    <= b_n;
            din_r    <= din_n;
            res_data <= res_n;
            err_code <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        b_n     = b_reg;
        din_n   = din_r;
        res_n   = res_data;
        err_n   = err_code;
        case (state)
            IDLE: if (tok_valid) begin
                if (!tok_is_op) begin
                    if (stk_full) begin
                        state_n = ERR;
                        err_n   = 2'b01;
                        res_n   = '0;
                    end else begin
                        state_n = PUSH;
                        din_n   = tok_data;
                    end
                end else if (tok_data[1:0] == 2'b11) begin
                    if (stk_size == SW'(1)) begin
                        state_n = DONE;
                        res_n   = stk_dout;
                        err_n   = 2'b00;
                    end else begin
                        state_n = ERR;
                        err_n   = 2'b11;
                        res_n   = '0;
                    end
                end else if (stk_size < SW'(2)) begin
                    state_n = ERR;
                    err_n   = 2'b10;
                    res_n   = '0;
                end else begin
                    state_n = POP_B;
                    op_n    = tok_data[1:0];
                end
            end
            PUSH:    state_n = IDLE;
            POP_B: begin
                b_n     = stk_dout;
                state_n = EXEC;
            end
            EXEC:    state_n = IDLE;
            DONE:    state_n = IDLE;
            ERR:     state_n = stk_empty ? IDLE : FLUSH;
            FLUSH:   state_n = (stk_size <= SW'(1)) ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    // the deeper operand is still on top of the stack during EXEC
    assign alu = (op == 2'b00) ? stk_dout + b_reg :
                 (op == 2'b01) ? stk_dout - b_reg : stk_dout * b_reg;

    assign stk_din   = (state == EXEC) ? alu : din_r;
    assign tok_ready = state == IDLE;
    assign stk_push  = state == PUSH || state == EXEC;
    assign stk_pop   = state == POP_B || state == EXEC || state == DONE || state == FLUSH;
    assign res_valid = state == DONE || state == ERR;
endmodule
